// File: rtl/alu_pkg.sv
// Shared types and ALU control encoding for the ALU arbiter slice.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] ALU_CTL_ADD     = 4'b0000;
    localparam logic [3:0] ALU_CTL_ADD_OVF = 4'b0001;
    localparam logic [3:0] ALU_CTL_SUB     = 4'b0010;
    localparam logic [3:0] ALU_CTL_SUB_OVF = 4'b0011;
    // Operation classes selected by ctl[3:2]; ctl[1:0] picks the variant.
    localparam logic [1:0] ALU_CLS_ARITH   = 2'b00;
    localparam logic [1:0] ALU_CLS_LOGIC   = 2'b01;
    localparam logic [1:0] ALU_CLS_SLT     = 2'b10;
    localparam logic [1:0] ALU_CLS_SHIFT   = 2'b11;

    typedef logic req_id_t;

    typedef enum logic {EMPTY, FULL} rsp_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, shared-ALU and response signals of the ALU arbiter.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) ();

    logic            req0_valid;
    logic            req1_valid;
    logic            req0_ready;
    logic            req1_ready;
    logic [XLEN-1:0] req0_da;
    logic [XLEN-1:0] req0_db;
    logic [XLEN-1:0] req1_da;
    logic [XLEN-1:0] req1_db;
    logic [3:0]      req0_ctl;
    logic [3:0]      req1_ctl;

    logic [XLEN-1:0] alu_da;
    logic [XLEN-1:0] alu_db;
    logic [3:0]      alu_ctl;
    logic [XLEN-1:0] alu_dc;
    logic            alu_zero;
    logic            alu_overflow;

    logic            rsp_valid;
    logic            rsp_ready;
    req_id_t         rsp_id;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_zero;
    logic            rsp_overflow;

    modport slave (
        input  req0_valid, req1_valid, req0_da, req0_db, req1_da, req1_db,
               req0_ctl, req1_ctl, alu_dc, alu_zero, alu_overflow, rsp_ready,
        output req0_ready, req1_ready, alu_da, alu_db, alu_ctl,
               rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_overflow
    );

    modport master (
        output req0_valid, req1_valid, req0_da, req0_db, req1_da, req1_db,
               req0_ctl, req1_ctl, alu_dc, alu_zero, alu_overflow, rsp_ready,
        input  req0_ready, req1_ready, alu_da, alu_db, alu_ctl,
               rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_overflow
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester grant logic: lone requester wins, a tie goes to the one
// that was not granted last (ptr holds the last granted id).
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       en,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (valid0 && valid1) begin
                gnt = ptr ? 2'b01 : 2'b10;
            end else if (valid0) begin
                gnt = 2'b01;
            end else if (valid1) begin
                gnt = 2'b10;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one combinational ALU and holds the result
// in a one-entry register. Define ALU_ARB_RR_EN for round-robin, else fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    rsp_state_t      state_q;
    rsp_state_t      state_d;
    logic [1:0]      gnt;
    logic            accept;
    logic            grant_any;
    req_id_t         gnt_id;
    logic            ptr;

    logic [XLEN-1:0] data_p1;
    logic            zero_p1;
    logic            ovf_p1;
    req_id_t         id_p1;

    // Gating with rst_n keeps both grants low for the whole reset window.
    assign accept    = rst_n && ((state_q == EMPTY) || bus.rsp_ready);
    assign grant_any = |gnt;
    assign gnt_id    = gnt[1];

    rr_arb2 u_rr_arb2 (
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .en     (accept),
        .ptr    (ptr),
        .gnt    (gnt)
    );

`ifdef ALU_ARB_RR_EN
    req_id_t last_gnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
        end else if (grant_any) begin
            last_gnt_q <= gnt_id;
        end
    end

    assign ptr = last_gnt_q;
`else
    assign ptr = 1'b1;
`endif

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

    assign bus.alu_da  = gnt_id ? bus.req1_da  : bus.req0_da;
    assign bus.alu_db  = gnt_id ? bus.req1_db  : bus.req0_db;
    assign bus.alu_ctl = gnt_id ? bus.req1_ctl : bus.req0_ctl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (grant_any) state_d = FULL;
            FULL:  if (bus.rsp_ready && !grant_any) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // ---- stage p1: result register, loaded on every grant ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            zero_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
            id_p1   <= 1'b0;
        end else if (grant_any) begin
            data_p1 <= bus.alu_dc;
            zero_p1 <= bus.alu_zero;
            ovf_p1  <= bus.alu_overflow;
            id_p1   <= gnt_id;
        end
    end

    assign bus.rsp_valid    = (state_q == FULL);
    assign bus.rsp_id       = id_p1;
    assign bus.rsp_data     = data_p1;
    assign bus.rsp_zero     = zero_p1;
    assign bus.rsp_overflow = ovf_p1;

endmodule
